// File: rtl/bus_timer_pkg.sv
// Shared register-map constants for the countdown timer and other bus peripherals.
// Register indices and CTRL bit positions are fixed by the processor-side software.
package bus_timer_pkg;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_LOAD   = 2'd1,
      REG_COUNT  = 2'd2,
      REG_STATUS = 2'd3
   } reg_idx_e;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_AUTO = 1;

endpackage

// File: rtl/bus_timer_if.sv
// Processor-side bus bundle for the timer: select, index, write data/strobe, read data, done level.
interface bus_timer_if;

   logic        cs;
   logic [1:0]  ADDR;
   logic [15:0] DOUT;
   logic        W;
   logic [15:0] q;
   logic        done;

   modport master (output cs, output ADDR, output DOUT, output W, input q, input done);
   modport slave  (input cs, input ADDR, input DOUT, input W, output q, output done);

endinterface

// File: rtl/bus_timer_tick_gen.sv
// Prescaler: counts enabled cycles and flags the last cycle of every PRESCALE-cycle period.
module tick_gen #(
   parameter int unsigned PRESCALE = 50000,
   parameter int unsigned PW       = 16
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;

   // tick ignores clr so a same-cycle CTRL write still lets the count update land
   assign tick = en && (cnt == LAST);

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         cnt <= '0;
      end else if (clr || !en || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped countdown timer: CTRL/LOAD/COUNT/STATUS registers, one-cycle registered reads.
module bus_timer
   import bus_timer_pkg::*;
#(
   parameter int unsigned PRESCALE = 50000,
   parameter int unsigned PW       = 16
) (
   input  logic       Clock,
   input  logic       Resetn,
   bus_timer_if.slave bus
);

   logic        en_r;
   logic        auto_r;
   logic        done_r;
   logic [15:0] load_r;
   logic [15:0] count_r;
   logic [15:0] q_r;
   logic [15:0] rd_data;
   logic        tick;
   logic        wr;
   logic        ctrl_wr;
   reg_idx_e    idx;

   assign idx     = reg_idx_e'(bus.ADDR);
   assign wr      = bus.cs & bus.W;
   assign ctrl_wr = wr && (idx == REG_CTRL);

   tick_gen #(.PRESCALE(PRESCALE), .PW(PW)) u_tick_gen (
      .Clock  (Clock),
      .Resetn (Resetn),
      .en     (en_r),
      .clr    (ctrl_wr),
      .tick   (tick)
   );

   always_comb begin
      rd_data = '0;
      case (idx)
         REG_CTRL:   begin
            rd_data[CTRL_EN]   = en_r;
            rd_data[CTRL_AUTO] = auto_r;
         end
         REG_LOAD:   rd_data = load_r;
         REG_COUNT:  rd_data = count_r;
         REG_STATUS: rd_data[0] = done_r;
         default:    rd_data = '0;
      endcase
   end

   // Later assignments win: STATUS clear < tick effects < register writes
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         en_r    <= 1'b0;
         auto_r  <= 1'b0;
         done_r  <= 1'b0;
         load_r  <= '0;
         count_r <= '0;
         q_r     <= '0;
      end else begin
         q_r <= rd_data;

         if (wr && (idx == REG_STATUS)) begin
            done_r <= 1'b0;
         end

         if (tick) begin
            if (count_r != '0) begin
               count_r <= count_r - 1'b1;
               if (count_r == 16'd1) begin
                  done_r <= 1'b1;
               end
            end else if (auto_r) begin
               count_r <= load_r;
            end else begin
               en_r <= 1'b0;
            end
         end

         if (wr) begin
            case (idx)
               REG_CTRL: begin
                  en_r   <= bus.DOUT[CTRL_EN];
                  auto_r <= bus.DOUT[CTRL_AUTO];
               end
               REG_LOAD: begin
                  load_r  <= bus.DOUT;
                  count_r <= bus.DOUT;
               end
               REG_COUNT:  count_r <= bus.DOUT;
               REG_STATUS: ;
               default:    ;
            endcase
         end
      end
   end

   assign bus.q    = q_r;
   assign bus.done = done_r;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer (PRESCALE=4): per-cycle model comparison plus literal checkpoints.
module tb_bus_timer;

   localparam int unsigned P = 4;

   logic clk;
   logic resetn;
   int   n_checks;
   int   n_fail;

   bus_timer_if bus ();

   bus_timer #(.PRESCALE(P), .PW(16)) dut (
      .Clock  (clk),
      .Resetn (resetn),
      .bus    (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: timer state as plain values, elapsed enabled cycles decide tick instants.
   logic        m_valid;
   logic        m_en, m_auto, m_done;
   logic [15:0] m_load, m_count, m_q;
   int          m_phase;

   function automatic logic [15:0] model_read(input logic [1:0] a);
      case (a)
         2'd0:    return {14'd0, m_auto, m_en};
         2'd1:    return m_load;
         2'd2:    return m_count;
         default: return {15'd0, m_done};
      endcase
   endfunction

   always @(posedge clk) begin
      logic        tk, wr, n_en, n_auto, n_done;
      logic [15:0] n_load, n_count;
      if (!resetn) begin
         m_valid = 1'b1;
         m_en = 0; m_auto = 0; m_done = 0;
         m_load = 0; m_count = 0; m_q = 0; m_phase = 0;
      end else begin
         tk = m_en && ((m_phase % P) == P - 1);
         wr = bus.cs && bus.W;
         n_en = m_en; n_auto = m_auto; n_done = m_done;
         n_load = m_load; n_count = m_count;
         if (tk) begin
            if (m_count > 0) begin
               n_count = m_count - 16'd1;
               if (n_count == 0) n_done = 1'b1;
            end else if (m_auto) n_count = m_load;
            else n_en = 1'b0;
         end
         if (wr) begin
            case (bus.ADDR)
               2'd0: begin n_en = bus.DOUT[0]; n_auto = bus.DOUT[1]; end
               2'd1: begin n_load = bus.DOUT; n_count = bus.DOUT; end
               2'd2: n_count = bus.DOUT;
               default: if (!(tk && m_count == 16'd1)) n_done = 1'b0;
            endcase
         end
         m_q = model_read(bus.ADDR);
         m_phase = (!m_en || (wr && bus.ADDR == 2'd0)) ? 0 : m_phase + 1;
         m_en = n_en; m_auto = n_auto; m_done = n_done;
         m_load = n_load; m_count = n_count;
      end
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_q", bus.q, m_q);
         check("model_done", {15'd0, bus.done}, {15'd0, m_done});
      end
   end

   // All stimulus tasks start and end 1 time unit after a rising edge.
   task automatic idle(input int n);
      bus.cs = 1'b0; bus.W = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
      bus.cs = 1'b1; bus.W = 1'b1; bus.ADDR = a; bus.DOUT = d;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.W = 1'b0;
   endtask

   task automatic rd_reg(input logic [1:0] a);
      bus.cs = 1'b1; bus.W = 1'b0; bus.ADDR = a;
      @(posedge clk); #1;
      bus.cs = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; m_valid = 1'b0;
      resetn = 1'b0;
      bus.cs = 0; bus.W = 0; bus.ADDR = 0; bus.DOUT = 0;

      // 1. reset values
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd_reg(2'(i));
         check("reset_read", bus.q, 16'h0000);
      end
      check("reset_done", {15'd0, bus.done}, 16'h0000);

      // 2. one-shot: COUNT 3,2,1,0 at 4-cycle steps, EN self-clears
      wr_reg(2'd1, 16'd3);
      wr_reg(2'd0, 16'h0001);
      bus.ADDR = 2'd2;
      idle(11);
      check("oneshot_done_before", {15'd0, bus.done}, 16'h0000);
      idle(1);
      check("oneshot_done_rise", {15'd0, bus.done}, 16'h0001);
      check("oneshot_q_prev", bus.q, 16'd1);
      idle(1);
      check("oneshot_count0", bus.q, 16'd0);
      idle(5);
      rd_reg(2'd0);
      check("oneshot_ctrl_off", bus.q, 16'h0000);
      bus.ADDR = 2'd2;
      idle(20);
      check("oneshot_hold0", bus.q, 16'h0000);

      // 3. auto-reload
      wr_reg(2'd3, 16'hFFFF);
      check("status_clear", {15'd0, bus.done}, 16'h0000);
      wr_reg(2'd1, 16'd2);
      wr_reg(2'd0, 16'h0003);
      bus.ADDR = 2'd2;
      idle(8);
      check("auto_done1", {15'd0, bus.done}, 16'h0001);
      wr_reg(2'd3, 16'h0000);
      check("auto_clear", {15'd0, bus.done}, 16'h0000);
      bus.ADDR = 2'd2;
      idle(11);
      check("auto_done_again", {15'd0, bus.done}, 16'h0001);

      // 4. collisions: clear vs set, COUNT write vs tick
      wr_reg(2'd3, 16'h0000);
      bus.ADDR = 2'd2;
      idle(10);
      wr_reg(2'd3, 16'h0000);
      check("clear_vs_set", {15'd0, bus.done}, 16'h0001);
      bus.ADDR = 2'd2;
      idle(3);
      wr_reg(2'd2, 16'h0010);
      rd_reg(2'd2);
      check("write_vs_tick", bus.q, 16'h0010);

      // 5. read-during-write returns old value
      wr_reg(2'd0, 16'h0000);
      wr_reg(2'd2, 16'd5);
      wr_reg(2'd2, 16'h00AA);
      check("rdw_old", bus.q, 16'h0005);
      rd_reg(2'd2);
      check("rdw_new", bus.q, 16'h00AA);

      // 6. reset mid-operation
      wr_reg(2'd2, 16'd7);
      wr_reg(2'd0, 16'h0001);
      bus.ADDR = 2'd2;
      idle(2);
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      check("midreset_q", bus.q, 16'h0000);
      check("midreset_done", {15'd0, bus.done}, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         rd_reg(2'(i));
         check("midreset_read", bus.q, 16'h0000);
      end
      bus.ADDR = 2'd2;
      idle(4);
      check("midreset_no_tick", bus.q, 16'h0000);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped countdown-timer responder on the processor's 16-bit bus (ADDR/DOUT/W/DIN).
- The top level decodes ADDR[15:12]==4'h2 into cs. The timer returns read data with one-cycle registered latency, matching the synchronous instruction memory, so the top-level DIN mux selects q when cs is set.
- done is also exported as a level for LEDR and polling.

Parameters:
PRESCALE, 50000, Clock cycles per timer tick (1 ms at 50 MHz); minimum 1
PW, 16, prescaler counter width; must satisfy 2^PW > PRESCALE

Ports:
Clock  in  1  system clock; all state updates on rising edge
Resetn  in  1  synchronous active-low reset, sampled on rising edge of Clock
cs  in  1  chip select decoded from ADDR[15:12]
ADDR  in  2  register index, driven from processor ADDR[1:0]
DOUT  in  16  processor write data
W  in  1  processor write strobe; a write occurs when cs & W at the edge
q  out  16  registered read data for the DIN mux
done  out  1  sticky expiry flag (STATUS[0])

Behaviour:
- Register map, by ADDR:
  - 0 CTRL: [0]=EN, [1]=AUTO; other bits read 0.
  - 1 LOAD: reload value, 16 bits.
  - 2 COUNT: current count.
  - 3 STATUS: [0]=DONE; other bits read 0.
- Reset (Resetn==0 at edge):
  - EN=0, AUTO=0, LOAD=0, COUNT=0, DONE=0, prescaler=0, q=16'h0000.
  - Reset takes priority over every other event, including mid-count and mid-write.
- Read path:
  - Every edge, q <= register selected by ADDR, regardless of cs or W.
  - Read latency is 1 cycle.
  - Old-data semantics: a read and a write to the same register in one cycle return the pre-write value.
- Writes (cs & W):
  - CTRL: EN<=DOUT[0], AUTO<=DOUT[1], prescaler<=0.
  - LOAD: LOAD<=DOUT and COUNT<=DOUT.
  - COUNT: COUNT<=DOUT.
  - STATUS: DONE<=0; the data value is ignored.
- Prescaler:
  - When EN=1, it increments each cycle. On reaching PRESCALE-1 it wraps to 0 and asserts tick for one cycle.
  - When EN=0, it holds at 0 and no ticks occur.
- On tick:
  - COUNT!=0: COUNT<=COUNT-1. If the result is 0, DONE<=1.
  - COUNT==0, AUTO=1: COUNT<=LOAD. This gives a period of (LOAD+1) ticks after the first expiry.
  - COUNT==0, AUTO=0: EN<=0, COUNT holds 0.
  - DONE is not re-set on the zero-hold tick; it is set only on the 1->0 transition.
- Simultaneous events:
  - A bus write to COUNT or LOAD in the same cycle as a tick: the write wins and the tick's COUNT update is discarded.
  - STATUS clear in the same cycle as a DONE set: the set wins, so DONE=1.
  - CTRL write in the same cycle as a tick: the CTRL write wins, the prescaler is cleared, and the tick's COUNT update still applies.
- Arithmetic:
  - COUNT is unsigned 16-bit.
  - LOAD=0 with EN=1: first tick with COUNT 0 reloads 0 when AUTO=1, or disables when AUTO=0. DONE is never set.
- done = DONE, registered with no combinational path from inputs.
- The timer never drives the bus when cs=0. The top-level mux ignores q in that case.

Decomposition:
- Shared package: register-index constants (REG_CTRL=2'd0, REG_LOAD=2'd1, REG_COUNT=2'd2, REG_STATUS=2'd3) and CTRL bit positions (CTRL_EN=0, CTRL_AUTO=1). The top level and future peripherals reuse these constants.
- One sub-module, tick_gen (prescaler: Clock, Resetn, en, clr -> tick), parameterised by PRESCALE and PW.
- The register file and countdown logic stay in bus_timer.

Test Plan (PRESCALE=4):
1. Reset values: hold Resetn=0 for 3 cycles, then read ADDR 0..3 -> q is 0 for each, one cycle after each address; done=0.
2. One-shot: write LOAD=3, then CTRL=16'h0001 -> COUNT steps 3,2,1,0 at 4-cycle intervals. done rises on the 0 transition. CTRL then reads 16'h0000, and COUNT holds 0 for 20 further cycles.
3. Auto-reload:
   - Stimulus: write LOAD=2, then CTRL=16'h0003.
   - COUNT sequence: 2,1,0,2,1,0...
   - done stays 1.
   - STATUS write clears done.
   - done re-asserts on the next 1->0 transition.
4. Collisions:
   - STATUS write on the exact cycle COUNT goes 1->0 -> done=1.
   - COUNT write of 16'h0010 on a tick cycle -> COUNT=16'h0010, not decremented.
5. Read-during-write: write COUNT=16'h00AA with ADDR=2 while COUNT=5 -> q next cycle = 16'h0005; the following read returns 16'h00AA.
6. Reset mid-operation: assert Resetn=0 for one edge while EN=1 and COUNT=7 -> all registers and q are 0 at that edge; no tick occurs for at least 4 cycles after release.
